m68k_bus_master: RTL and testbench

- Synchronous 68000-style bus initiator.
- Converts a simple single-beat req/done command interface into AS/UDS/LDS/RW cycles on a 23-bit word-address, 16-bit data bus.
- Terminates each cycle on DTACK or VPA from a responder like the CPU-bus decode in the system top.
- Used by DMA/test engines that share the peripheral bus (RAM, tilemap, palette, CRTC, vio) with the 68000.

---
 rtl/m68k_bus_master.sv | 159 +++++++++++++++
 tb/tb_m68k_bus_master.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/m68k_bus_master.sv
// 68000-style bus initiator: turns single-beat req/done commands into AS/UDS/LDS/RW cycles.
// Optional WAIT-state abort is enabled by defining M68K_BUS_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | ready, waiting for req
// ADDR    | address/rw on bus, AS about to fall (reads also drop DS)
// ASSERT  | AS low; writes drop DS here so data settles before DS
// DSTB    | strobes low, entering WAIT
// WAIT    | waiting for DTACK or VPA (or timeout)
// END     | strobes released, done pulse
// RECOVER | waiting for responder to release DTACK/VPA
module m68k_bus_master #(
  parameter int ADDR_W  = 23,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_be,
  input  logic [15:0]       req_wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [15:0]       rdata,
  output logic [ADDR_W-1:0] eab,
  output logic              rw,
  output logic              as_n,
  output logic              uds_n,
  output logic              lds_n,
  output logic [15:0]       oedb,
  input  logic [15:0]       iedb,
  input  logic              dtack_n,
  input  logic              vpa_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ASSERT, S_DSTB, S_WAIT, S_END, S_RECOVER
  } state_t;

  state_t     state;
  logic       we;
  logic [1:0] be;
  logic       ack;

  assign ack = ~dtack_n | ~vpa_n;

`ifdef M68K_BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] tmr;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      we    <= 1'b0;
      be    <= 2'b00;
      ready <= 1'b1;
      done  <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
      eab   <= '0;
      rw    <= 1'b1;
      as_n  <= 1'b1;
      uds_n <= 1'b1;
      lds_n <= 1'b1;
      oedb  <= '0;
`ifdef M68K_BUS_TIMEOUT_EN
      tmr   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            eab   <= req_addr;
            oedb  <= req_wdata;
            rw    <= ~req_we;
            we    <= req_we;
            be    <= req_be;
            ready <= 1'b0;
            if (req_be == 2'b00) begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= S_END;
            end else begin
              state <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          as_n <= 1'b0;
          if (!we) begin
            uds_n <= ~be[1];
            lds_n <= ~be[0];
          end
          state <= S_ASSERT;
        end
        S_ASSERT: begin
          if (we) begin
            uds_n <= ~be[1];
            lds_n <= ~be[0];
          end
          state <= S_DSTB;
        end
        S_DSTB: begin
`ifdef M68K_BUS_TIMEOUT_EN
          tmr <= CNT_LOAD;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (ack) begin
            if (!we) rdata <= iedb;
            as_n  <= 1'b1;
            uds_n <= 1'b1;
            lds_n <= 1'b1;
            done  <= 1'b1;
            err   <= 1'b0;
            state <= S_END;
          end
`ifdef M68K_BUS_TIMEOUT_EN
          else if (tmr == '0) begin
            as_n  <= 1'b1;
            uds_n <= 1'b1;
            lds_n <= 1'b1;
            done  <= 1'b1;
            err   <= 1'b1;
            state <= S_END;
          end else begin
            tmr <= tmr - 1'b1;
          end
`endif
        end
        S_END: begin
          done <= 1'b0;
          err  <= 1'b0;
          rw   <= 1'b1;
          // A responder that has already let go needs no RECOVER cycle.
          if (!ack) begin
            ready <= 1'b1;
            state <= S_IDLE;
          end else begin
            state <= S_RECOVER;
          end
        end
        S_RECOVER: begin
          if (!ack) begin
            ready <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_bus_master.sv
// Directed self-checking bench for m68k_bus_master with a negedge-driven responder model.
module tb_m68k_bus_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req, req_we;
  logic [22:0] req_addr;
  logic [1:0]  req_be;
  logic [15:0] req_wdata;
  logic        ready, done, err;
  logic [15:0] rdata;
  logic [22:0] eab;
  logic        rw, as_n, uds_n, lds_n;
  logic [15:0] oedb;
  logic [15:0] iedb;
  logic        dtack_n = 1'b1, vpa_n = 1'b1;

  int checks = 0;
  int errors = 0;

  // responder controls: ack_sel 0=dtack 1=vpa 2=never
  int ack_dly = 2, ack_sel = 0, hold = 0;
  int lo_cnt = 0, hi_cnt = 0;
  bit ack_on = 1'b0;

  always #5 clk = ~clk;

  m68k_bus_master #(.ADDR_W(23), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_be(req_be), .req_wdata(req_wdata), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .eab(eab), .rw(rw), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n),
    .oedb(oedb), .iedb(iedb), .dtack_n(dtack_n), .vpa_n(vpa_n)
  );

  always @(negedge clk) begin
    if (!reset_n) begin
      lo_cnt = 0; hi_cnt = 0; ack_on = 1'b0;
    end else if (!as_n) begin
      lo_cnt++;
      hi_cnt = 0;
      if (lo_cnt >= ack_dly && ack_sel != 2) ack_on = 1'b1;
    end else begin
      lo_cnt = 0;
      if (ack_on) begin
        if (hi_cnt >= hold) ack_on = 1'b0;
        else hi_cnt++;
      end
    end
    dtack_n = !(ack_on && ack_sel == 0);
    vpa_n   = !(ack_on && ack_sel == 1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // drives req for exactly one edge; returns 1 ns after the accepting edge
  task automatic issue(input logic we, input logic [22:0] a, input logic [1:0] b,
                       input logic [15:0] d);
    req = 1'b1; req_we = we; req_addr = a; req_be = b; req_wdata = d;
    step();
    req = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 40) begin
      step();
      n++;
    end
    check(tag, 32'(ready), 32'd1);
  endtask

  initial begin
    int n_done, n_as;
    logic prev_as;
    reset_n = 1'b0; req = 1'b0; req_we = 1'b0; req_addr = '0; req_be = 2'b00;
    req_wdata = '0; iedb = 16'h0000;
    step(2);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_strobes", {29'd0, as_n, uds_n, lds_n}, 32'h7);
    check("rst_rw", 32'(rw), 32'd1);
    check("rst_rdata", 32'(rdata), 32'h0);
    @(negedge clk) reset_n = 1'b1;
    step();

    // read, both lanes, dtack
    iedb = 16'hBEEF; ack_sel = 0; ack_dly = 2; hold = 0;
    issue(1'b0, 23'h080000, 2'b11, 16'h0000);
    check("rd_ready_low", 32'(ready), 32'd0);
    check("rd_eab", 32'(eab), 32'h080000);
    check("rd_rw", 32'(rw), 32'd1);
    check("rd_as_addr", 32'(as_n), 32'd1);
    step();
    check("rd_strobes", {29'd0, as_n, uds_n, lds_n}, 32'h0);
    step(2);
    check("rd_no_early_done", 32'(done), 32'd0);
    step();
    check("rd_done", 32'(done), 32'd1);
    check("rd_err", 32'(err), 32'd0);
    check("rd_rdata", 32'(rdata), 32'hBEEF);
    check("rd_end_strobes", {29'd0, as_n, uds_n, lds_n}, 32'h7);
    step();
    check("rd_done_pulse", 32'(done), 32'd0);
    wait_ready("rd_ready");

    // write, lower lane
    iedb = 16'hDEAD;
    issue(1'b1, 23'h001234, 2'b01, 16'h1234);
    check("wr_rw", 32'(rw), 32'd0);
    check("wr_oedb", 32'(oedb), 32'h1234);
    step();
    check("wr_as_fall", {29'd0, as_n, uds_n, lds_n}, 32'h3);
    step();
    check("wr_lds_fall", {29'd0, as_n, uds_n, lds_n}, 32'h2);
    step(2);
    check("wr_done", 32'(done), 32'd1);
    check("wr_err", 32'(err), 32'd0);
    check("wr_rw_end", 32'(rw), 32'd0);
    check("wr_rdata_kept", 32'(rdata), 32'hBEEF);
    step();
    check("wr_rw_release", 32'(rw), 32'd1);
    wait_ready("wr_ready");

    // read, upper lane, vpa held 3 cycles after AS rises
    iedb = 16'h5A5A; ack_sel = 1; hold = 3;
    issue(1'b0, 23'h000010, 2'b10, 16'h0000);
    step();
    check("vpa_strobes", {29'd0, as_n, uds_n, lds_n}, 32'h1);
    step(3);
    check("vpa_done", 32'(done), 32'd1);
    check("vpa_rdata", 32'(rdata), 32'h5A5A);
    step(3);
    check("vpa_still_busy", 32'(ready), 32'd0);
    check("vpa_held", 32'(vpa_n), 32'd0);
    step();
    check("vpa_ready", 32'(ready), 32'd1);
    hold = 0; ack_sel = 0;
    step();

    // no lanes: immediate error, no bus cycle
    issue(1'b0, 23'h000020, 2'b00, 16'h0000);
    check("be0_done", 32'(done), 32'd1);
    check("be0_err", 32'(err), 32'd1);
    check("be0_as", 32'(as_n), 32'd1);
    step();
    check("be0_done_pulse", 32'(done), 32'd0);
    check("be0_as2", 32'(as_n), 32'd1);
    check("be0_ready", 32'(ready), 32'd1);

    // back-to-back with zero-wait responder
    iedb = 16'hC0DE; ack_dly = 1;
    req = 1'b1; req_we = 1'b0; req_addr = 23'h000100; req_be = 2'b11;
    n_done = 0; n_as = 0; prev_as = as_n;
    for (int s = 0; s < 30; s++) begin
      step();
      if (done) n_done++;
      if (!as_n && prev_as) n_as++;
      prev_as = as_n;
    end
    req = 1'b0;
    check("b2b_done_count", 32'(n_done), 32'd5);
    check("b2b_as_count", 32'(n_as), 32'd5);
    check("b2b_rdata", 32'(rdata), 32'hC0DE);
    wait_ready("b2b_ready");

    // reset while stuck in WAIT
    ack_sel = 2;
    issue(1'b0, 23'h000200, 2'b11, 16'h0000);
    step(4);
    check("rstw_as_low", 32'(as_n), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("rstw_strobes", {29'd0, as_n, uds_n, lds_n}, 32'h7);
    check("rstw_ready", 32'(ready), 32'd1);
    check("rstw_done", 32'(done), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    n_done = 0;
    for (int s = 0; s < 6; s++) begin
      step();
      if (done) n_done++;
    end
    check("rstw_no_done", 32'(n_done), 32'd0);

`ifdef M68K_BUS_TIMEOUT_EN
    // no acknowledge at all: abort after 16 WAIT cycles
    issue(1'b0, 23'h000300, 2'b11, 16'h0000);
    step(18);
    check("to_not_yet", 32'(done), 32'd0);
    step();
    check("to_done", 32'(done), 32'd1);
    check("to_err", 32'(err), 32'd1);
    check("to_as", 32'(as_n), 32'd1);
    check("to_rdata", 32'(rdata), 32'hC0DE);
    wait_ready("to_ready");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
